// File: rtl/ltp_pkg.sv
// ltp_pkg: shared definitions for the multi-channel level-to-pulse converter.
//   - edge-mode encodings used by the EDGE parameter
//   - per-channel FSM state type
//   - cnt_width(): counter width needed to hold values 0..max_val-1
package ltp_pkg;

    localparam int EDGE_RISE = 32'sd0;
    localparam int EDGE_FALL = 32'sd1;
    localparam int EDGE_BOTH = 32'sd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        HOLD  = 2'd2
    } ltp_state_e;

    // Bits needed for a down-counter loaded with at most max_val-1 (never below 1 bit).
    function automatic int cnt_width(input int max_val);
        if (max_val <= 32'sd1) begin
            return 32'sd1;
        end else begin
            return $clog2(max_val);
        end
    endfunction

endpackage

// File: rtl/ltp_multi_if.sv
// ltp_multi_if: control/data bundle of the level-to-pulse converter.
//   i_en     global enable (driven by master)
//   i_level  per-channel level inputs (driven by master)
//   o_pulse  per-channel registered pulses (driven by converter)
//   o_any    OR of o_pulse (driven by converter)
interface ltp_multi_if #(
    parameter int N_CH = 4
);
    logic            i_en;
    logic [N_CH-1:0] i_level;
    logic [N_CH-1:0] o_pulse;
    logic            o_any;

    modport master (output i_en, output i_level, input o_pulse, input o_any);
    modport slave  (input i_en, input i_level, output o_pulse, output o_any);
endinterface

// File: rtl/ltp_ch.sv
// ltp_ch: one level-to-pulse channel.
//   Synchronises i_level (SYNC_STAGES flops, 0 = already in the i_clk domain),
//   detects the selected edge, emits a PULSE_W-cycle pulse and optionally
//   auto-repeats while the level stays active.
// Ports:
//   i_clk, i_rstn  clock, asynchronous active-low reset
//   i_en           enable; low forces the FSM idle on the next edge
//   i_level        raw level input
//   o_pulse        registered pulse output
module ltp_ch
    import ltp_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int EDGE        = 0,
    parameter int PULSE_W     = 1,
    parameter int REPEAT_DLY  = 0,
    parameter int REPEAT_PER  = 0
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_en,
    input  logic i_level,
    output logic o_pulse
);

    localparam bit REP_EN  = (REPEAT_DLY > 32'sd0) && (EDGE != EDGE_BOTH);
    localparam int REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int WW      = cnt_width(PULSE_W);
    localparam int RW      = cnt_width(REP_MAX);

    localparam logic [WW-1:0] W_LOAD   = WW'(PULSE_W - 32'sd1);
    localparam logic [WW-1:0] W_ZERO   = {WW{1'b0}};
    localparam logic [WW-1:0] W_ONE    = WW'(32'd1);
    localparam logic [RW-1:0] R_ZERO   = {RW{1'b0}};
    localparam logic [RW-1:0] R_ONE    = RW'(32'd1);
    // Without repeat the repeat counter is parked at zero.
    localparam logic [RW-1:0] DLY_LOAD = REP_EN ? RW'(REPEAT_DLY - 32'sd1) : {RW{1'b0}};
    localparam logic [RW-1:0] PER_LOAD = REP_EN ? RW'(REPEAT_PER - 32'sd1) : {RW{1'b0}};

    logic s_s;
    logic p_r;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s_s = i_level;
        end else if (SYNC_STAGES == 1) begin : g_sync1
            logic sync_r;
            // Single-flop capture of the level.
            always_ff @(posedge i_clk or negedge i_rstn) begin
                if (!i_rstn) begin
                    sync_r <= 1'b0;
                end else begin
                    sync_r <= i_level;
                end
            end
            assign s_s = sync_r;
        end else begin : g_syncn
            logic [SYNC_STAGES-1:0] sync_r;
            // Shift the level through the synchroniser chain.
            always_ff @(posedge i_clk or negedge i_rstn) begin
                if (!i_rstn) begin
                    sync_r <= {SYNC_STAGES{1'b0}};
                end else begin
                    sync_r <= {sync_r[SYNC_STAGES-2:0], i_level};
                end
            end
            assign s_s = sync_r[SYNC_STAGES-1];
        end
    endgenerate

    // Previous synchronised value; tracks even when disabled so that
    // re-enabling with a held level does not look like an edge.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            p_r <= 1'b0;
        end else begin
            p_r <= s_s;
        end
    end

    logic trig_s;
    logic act_s;

    // Edge detect and "level active" for the selected mode.
    always_comb begin
        trig_s = 1'b0;
        act_s  = 1'b0;
        case (EDGE)
            EDGE_RISE: begin
                trig_s = s_s & ~p_r;
                act_s  = s_s;
            end
            EDGE_FALL: begin
                trig_s = ~s_s & p_r;
                act_s  = ~s_s;
            end
            EDGE_BOTH: begin
                trig_s = s_s ^ p_r;
                act_s  = 1'b0;
            end
            default: begin
                trig_s = 1'b0;
                act_s  = 1'b0;
            end
        endcase
    end

    ltp_state_e    state_r, state_nxt_s;
    logic [WW-1:0] wcnt_r, wcnt_nxt_s;
    logic [RW-1:0] rcnt_r, rcnt_nxt_s;
    logic          pulse_r;

    // Next-state logic: width counter times the pulse, repeat counter runs
    // from the trigger through PULSE and HOLD.
    always_comb begin
        state_nxt_s = state_r;
        wcnt_nxt_s  = wcnt_r;
        rcnt_nxt_s  = rcnt_r;
        if (!i_en) begin
            state_nxt_s = IDLE;
            wcnt_nxt_s  = W_ZERO;
            rcnt_nxt_s  = R_ZERO;
        end else begin
            case (state_r)
                IDLE: begin
                    if (trig_s) begin
                        state_nxt_s = PULSE;
                        wcnt_nxt_s  = W_LOAD;
                        rcnt_nxt_s  = DLY_LOAD;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                PULSE: begin
                    if (REP_EN) begin
                        rcnt_nxt_s = rcnt_r - R_ONE;
                    end else begin
                        rcnt_nxt_s = rcnt_r;
                    end
                    // Only both-edge mode can retrigger mid-pulse; it stretches the pulse.
                    if (trig_s && (EDGE == EDGE_BOTH)) begin
                        wcnt_nxt_s = W_LOAD;
                    end else if (wcnt_r == W_ZERO) begin
                        if (REP_EN && act_s) begin
                            state_nxt_s = HOLD;
                        end else begin
                            state_nxt_s = IDLE;
                        end
                    end else begin
                        wcnt_nxt_s = wcnt_r - W_ONE;
                    end
                end
                HOLD: begin
                    if (!act_s) begin
                        state_nxt_s = IDLE;
                        rcnt_nxt_s  = R_ZERO;
                    end else if (rcnt_r == R_ZERO) begin
                        state_nxt_s = PULSE;
                        wcnt_nxt_s  = W_LOAD;
                        rcnt_nxt_s  = PER_LOAD;
                    end else begin
                        rcnt_nxt_s = rcnt_r - R_ONE;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    wcnt_nxt_s  = W_ZERO;
                    rcnt_nxt_s  = R_ZERO;
                end
            endcase
        end
    end

    // State, counters and the registered pulse output.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_r <= IDLE;
            wcnt_r  <= W_ZERO;
            rcnt_r  <= R_ZERO;
            pulse_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            wcnt_r  <= wcnt_nxt_s;
            rcnt_r  <= rcnt_nxt_s;
            pulse_r <= (state_nxt_s == PULSE);
        end
    end

    assign o_pulse = pulse_r;

endmodule

// File: rtl/ltp_multi.sv
// ltp_multi: N_CH independent level-to-pulse channels sharing one enable.
// Ports:
//   i_clk, i_rstn  clock, asynchronous active-low reset
//   bus (slave)    i_en, i_level[N_CH] in; o_pulse[N_CH], o_any out
module ltp_multi
    import ltp_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE        = 0,
    parameter int PULSE_W     = 1,
    parameter int REPEAT_DLY  = 0,
    parameter int REPEAT_PER  = 0
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    ltp_multi_if.slave  bus
);

    generate
        if ((N_CH < 1) || (N_CH > 32) || (PULSE_W < 1) ||
            ((REPEAT_DLY > 0) && (EDGE != EDGE_BOTH) &&
             ((REPEAT_DLY <= PULSE_W) || (REPEAT_PER <= PULSE_W)))) begin : g_bad_params
            $error("ltp_multi: illegal parameter combination");
        end
    endgenerate

    logic [N_CH-1:0] pulse_s;

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            ltp_ch #(
                .SYNC_STAGES (SYNC_STAGES),
                .EDGE        (EDGE),
                .PULSE_W     (PULSE_W),
                .REPEAT_DLY  (REPEAT_DLY),
                .REPEAT_PER  (REPEAT_PER)
            ) u_ch (
                .i_clk   (i_clk),
                .i_rstn  (i_rstn),
                .i_en    (bus.i_en),
                .i_level (bus.i_level[i]),
                .o_pulse (pulse_s[i])
            );
        end
    endgenerate

    assign bus.o_pulse = pulse_s;
    assign bus.o_any   = |pulse_s;

endmodule
